// File: rtl/char_palette_arbiter.sv
// Round-robin arbiter sharing one 16-entry character palette between two sprite requesters.
// Optional grant counters are built when PAL_GRANT_CNT_EN is defined.
module char_palette_arbiter #(
   parameter logic [3:0] TRANSP_INDEX = 4'h0
`ifdef PAL_GRANT_CNT_EN
   ,
   parameter int unsigned CNT_W = 16
`endif
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] idx0,
   input  logic [3:0] idx1,
   output logic       gnt0,
   output logic       gnt1,
   output logic [3:0] pal_index,
   input  logic [3:0] pal_red,
   input  logic [3:0] pal_green,
   input  logic [3:0] pal_blue,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_red,
   output logic [3:0] rsp_green,
   output logic [3:0] rsp_blue,
   output logic       rsp_transparent
`ifdef PAL_GRANT_CNT_EN
   ,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
`endif
);

   logic       s1_valid_q, s1_valid_d;
   logic [3:0] pal_index_q, pal_index_d;
   logic       s1_id_q, s1_id_d;
   logic       last_id_q, last_id_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_id_q, rsp_id_d;
   logic [3:0] rsp_red_q, rsp_red_d;
   logic [3:0] rsp_green_q, rsp_green_d;
   logic [3:0] rsp_blue_q, rsp_blue_d;
   logic       rsp_transparent_q, rsp_transparent_d;
   logic       s2_free, s1_free, grant_en;

   assign s2_free  = ~rsp_valid_q | rsp_ready;
   assign s1_free  = ~s1_valid_q | s2_free;
   assign grant_en = Reset_n & s1_free;

   // On a tie the requester that did not win last time goes first.
   assign gnt0 = grant_en & req0 & (~req1 | last_id_q);
   assign gnt1 = grant_en & req1 & (~req0 | ~last_id_q);

   always_comb begin
      s1_valid_d        = s1_valid_q;
      pal_index_d       = pal_index_q;
      s1_id_d           = s1_id_q;
      last_id_d         = last_id_q;
      rsp_valid_d       = rsp_valid_q;
      rsp_id_d          = rsp_id_q;
      rsp_red_d         = rsp_red_q;
      rsp_green_d       = rsp_green_q;
      rsp_blue_d        = rsp_blue_q;
      rsp_transparent_d = rsp_transparent_q;

      if (s1_free) begin
         if (gnt0 | gnt1) begin
            s1_valid_d  = 1'b1;
            pal_index_d = gnt1 ? idx1 : idx0;
            s1_id_d     = gnt1;
            last_id_d   = gnt1;
         end else begin
            s1_valid_d  = 1'b0;
         end
      end

      if (s2_free) begin
         rsp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            rsp_id_d          = s1_id_q;
            rsp_red_d         = pal_red;
            rsp_green_d       = pal_green;
            rsp_blue_d        = pal_blue;
            rsp_transparent_d = (pal_index_q == TRANSP_INDEX);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         s1_valid_q        <= 1'b0;
         pal_index_q       <= 4'h0;
         s1_id_q           <= 1'b0;
         last_id_q         <= 1'b1;
         rsp_valid_q       <= 1'b0;
         rsp_id_q          <= 1'b0;
         rsp_red_q         <= 4'h0;
         rsp_green_q       <= 4'h0;
         rsp_blue_q        <= 4'h0;
         rsp_transparent_q <= 1'b0;
      end else begin
         s1_valid_q        <= s1_valid_d;
         pal_index_q       <= pal_index_d;
         s1_id_q           <= s1_id_d;
         last_id_q         <= last_id_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_id_q          <= rsp_id_d;
         rsp_red_q         <= rsp_red_d;
         rsp_green_q       <= rsp_green_d;
         rsp_blue_q        <= rsp_blue_d;
         rsp_transparent_q <= rsp_transparent_d;
      end
   end

   assign pal_index       = pal_index_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_id          = rsp_id_q;
   assign rsp_red         = rsp_red_q;
   assign rsp_green       = rsp_green_q;
   assign rsp_blue        = rsp_blue_q;
   assign rsp_transparent = rsp_transparent_q;

`ifdef PAL_GRANT_CNT_EN
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
   logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;

   // Free-running wrap at 2^CNT_W.
   always_comb begin
      gnt_cnt0_d = gnt_cnt0_q;
      gnt_cnt1_d = gnt_cnt1_q;
      if (gnt0) gnt_cnt0_d = gnt_cnt0_q + CntOne;
      if (gnt1) gnt_cnt1_d = gnt_cnt1_q + CntOne;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         gnt_cnt0_q <= '0;
         gnt_cnt1_q <= '0;
      end else begin
         gnt_cnt0_q <= gnt_cnt0_d;
         gnt_cnt1_q <= gnt_cnt1_d;
      end
   end

   assign gnt_cnt0 = gnt_cnt0_q;
   assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule
